// File: rtl/imem_boot_pkg.sv
// Shared types for the instruction-RAM boot loader / fetch arbiter.
// The CHECK/ERR states exist only when IMEM_BOOT_CHECKSUM_EN is defined.
package imem_boot_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int COUNT_W        = 16;

    typedef enum logic [2:0] {
        CNT_HI = 3'd0,
        CNT_LO = 3'd1,
        DATA   = 3'd2,
`ifdef IMEM_BOOT_CHECKSUM_EN
        CHECK  = 3'd3,
        ERR    = 3'd5,
`endif
        RUN    = 3'd4
    } state_t;

endpackage

// File: rtl/imem_word_assembler.sv
// Big-endian byte-to-word packer; word_valid fires with the 4th byte.
// The byte index is cleared by reset or by the synchronous clr input.
module imem_word_assembler
    import imem_boot_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [23:0] sh;
    logic [1:0]  idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh  <= '0;
            idx <= '0;
        end else if (clr) begin
            sh  <= '0;
            idx <= '0;
        end else if (byte_valid) begin
            sh  <= {sh[15:0], byte_data};
            idx <= idx + 2'd1;
        end
    end

    assign word_valid = byte_valid && (idx == 2'(BYTES_PER_WORD - 1));
    assign word       = {sh, byte_data};

endmodule

// File: rtl/imem_boot_arbiter.sv
// UART boot loader and fetch arbiter for the writable instruction RAM.
// Define IMEM_BOOT_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_boot_arbiter
    import imem_boot_pkg::*;
#(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] HOLD_NOP = 32'h00000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              boot_req,
    input  logic [31:0]       pc,
    output logic [31:0]       instruction,
    output logic              cpu_hold,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [31:0]       ram_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [31:0]       ram_wdata,
    output logic              boot_err
);

    localparam int DEPTH = 1 << ADDR_W;

    state_t             state;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] wcnt;
    logic               asm_clr;
    logic               word_valid;
    logic [31:0]        word;
    logic               in_range;
    logic               last_word;
    logic               unused;

`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [7:0] csum;
    logic       err_q;
    assign asm_clr  = boot_req && (state == RUN || state == ERR);
    assign boot_err = err_q;
`else
    assign asm_clr  = boot_req && (state == RUN);
    assign boot_err = 1'b0;
`endif

    imem_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clr        (asm_clr),
        .byte_valid (rx_valid && state == DATA),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    assign in_range  = 32'(wcnt) < 32'(DEPTH);
    assign last_word = wcnt == count - 16'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= CNT_HI;
            cpu_hold  <= 1'b1;
            ram_we    <= 1'b0;
            ram_waddr <= '0;
            ram_wdata <= '0;
            count     <= '0;
            wcnt      <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            csum      <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            ram_we <= 1'b0;
            unique case (state)
                CNT_HI: if (rx_valid) begin
                    count[15:8] <= rx_data;
                    state       <= CNT_LO;
                end
                CNT_LO: if (rx_valid) begin
                    count[7:0] <= rx_data;
                    if ({count[15:8], rx_data} == '0) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                        state    <= CHECK;
`else
                        state    <= RUN;
                        cpu_hold <= 1'b0;
`endif
                    end else begin
                        state <= DATA;
                    end
                end
                DATA: begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                    if (rx_valid) csum <= csum ^ rx_data;
`endif
                    if (word_valid) begin
                        // words beyond the RAM depth are swallowed
                        if (in_range) begin
                            ram_we    <= 1'b1;
                            ram_waddr <= wcnt[ADDR_W-1:0];
                            ram_wdata <= word;
                        end
                        if (wcnt != count) wcnt <= wcnt + 16'd1;
                        if (last_word) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                            state    <= CHECK;
`else
                            state    <= RUN;
                            cpu_hold <= 1'b0;
`endif
                        end
                    end
                end
`ifdef IMEM_BOOT_CHECKSUM_EN
                CHECK: if (rx_valid) begin
                    if (rx_data == csum) begin
                        state    <= RUN;
                        cpu_hold <= 1'b0;
                    end else begin
                        state <= ERR;
                        err_q <= 1'b1;
                    end
                end
                ERR: if (boot_req) begin
                    state <= CNT_HI;
                    err_q <= 1'b0;
                    wcnt  <= '0;
                    csum  <= '0;
                end
`endif
                RUN: if (boot_req) begin
                    state    <= CNT_HI;
                    cpu_hold <= 1'b1;
                    wcnt     <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
                    csum     <= '0;
`endif
                end
                default: state <= CNT_HI;
            endcase
        end
    end

    assign ram_raddr   = pc[ADDR_W+1:2];
    assign instruction = (cpu_hold || |pc[31:ADDR_W+2]) ? HOLD_NOP : ram_rdata;
    assign unused      = &{1'b0, pc[1:0]};

endmodule
